fix2flt_core: RTL and testbench

Synthesizable sequential converter from sign-magnitude fixed-point 8.8 to IEEE half-precision float. It is the inverse of the program-2 float-to-fixed path. It reads a 16-bit operand from data memory, normalizes it iteratively, rounds it to nearest-even, and writes the float16 result back to data memory. It uses the same start/done handshake as the other program engines, so the test bench drives it identically.

---
 rtl/fix2flt_pkg.sv | 30 +++
 rtl/fix2flt_if.sv | 25 ++
 rtl/fix2flt_round.sv | 36 +++
 rtl/fix2flt_core.sv | 114 +++++++++++
 tb/tb_fix2flt_core.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/fix2flt_pkg.sv
// Shared definitions for the fixed 8.8 to float16 converter.
// No ports. Holds state encodings, FP16/fixed-point field widths,
// the initial exponent and the data-memory operand/result addresses.
package fix2flt_pkg;

    localparam int EXP_W  = 5;
    localparam int MANT_W = 10;
    localparam int BIAS   = 15;
    localparam int FRAC_W = 8;
    localparam int MAG_W  = 15;

    // A magnitude whose leading one sits at bit MAG_W-1 has value
    // 2^(MAG_W-1-FRAC_W), so that position starts the exponent count.
    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + MAG_W - 1 - FRAC_W);

    localparam logic [7:0] SRC_ADDR = 8'd0;
    localparam logic [7:0] DST_ADDR = 8'd2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOAD_HI  = 3'd1;
    localparam state_t ST_LOAD_LO  = 3'd2;
    localparam state_t ST_NORM     = 3'd3;
    localparam state_t ST_ROUND    = 3'd4;
    localparam state_t ST_STORE_HI = 3'd5;
    localparam state_t ST_STORE_LO = 3'd6;
    localparam state_t ST_DONE     = 3'd7;

endpackage

// File: rtl/fix2flt_if.sv
// Program-engine bus: start/done handshake plus the byte-wide data-memory port.
//   start      : request from the bench, acted on at its falling edge
//   done       : one-cycle completion pulse
//   dm_addr    : data-memory address
//   dm_wr_en   : data-memory write enable
//   dm_wr_data : data-memory write byte
//   dm_rd_data : data-memory read byte (combinational read of dm_addr)
interface fix2flt_if;
    logic       start;
    logic       done;
    logic [7:0] dm_addr;
    logic       dm_wr_en;
    logic [7:0] dm_wr_data;
    logic [7:0] dm_rd_data;

    modport master (
        output start, dm_rd_data,
        input  done, dm_addr, dm_wr_en, dm_wr_data
    );

    modport slave (
        input  start, dm_rd_data,
        output done, dm_addr, dm_wr_en, dm_wr_data
    );
endinterface

// File: rtl/fix2flt_round.sv
// Round-to-nearest-even and float16 packing of a normalized magnitude.
//   sign_i   : operand sign
//   exp_i    : biased exponent matching the leading one at mag_i[14]
//   mag_i    : normalized magnitude (leading one at bit 14, or all zero)
//   result_o : packed {sign, exp, mant}
module fix2flt_round
    import fix2flt_pkg::*;
(
    input  logic                 sign_i,
    input  logic [EXP_W-1:0]     exp_i,
    input  logic [MAG_W-1:0]     mag_i,
    output logic [15:0]          result_o
);

    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              rnd_up;
    logic [MANT_W:0]   mant_sum;
    logic [EXP_W-1:0]  exp_out;

    always_comb begin
        mant     = mag_i[13:4];
        guard    = mag_i[3];
        sticky   = |mag_i[2:0];
        rnd_up   = guard && (sticky || mant[0]);
        mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, rnd_up};
        // An all-ones mantissa rounding up wraps to zero and bumps the exponent.
        exp_out  = exp_i + {{(EXP_W-1){1'b0}}, mant_sum[MANT_W]};
        if (mag_i == '0)
            result_o = {sign_i, 15'b0};
        else
            result_o = {sign_i, exp_out, mant_sum[MANT_W-1:0]};
    end

endmodule

// File: rtl/fix2flt_core.sv
// Sequential sign-magnitude 8.8 fixed-point to float16 converter.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of the start/done handshake and data-memory port
//
// state    | meaning
// IDLE     | wait for falling edge of start
// LOAD_HI  | read sign and m[14:8] from SRC_ADDR+1
// LOAD_LO  | read m[7:0] from SRC_ADDR, preset exponent
// NORM     | shift m left one bit per cycle until m[14] set or m zero
// ROUND    | round-to-nearest-even, register packed result
// STORE_HI | write result[15:8] to DST_ADDR+1
// STORE_LO | write result[7:0] to DST_ADDR
// DONE     | one-cycle done pulse
module fix2flt_core
    import fix2flt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    fix2flt_if.slave    bus
);

    state_t             state_q, state_d;
    logic               start_q;
    logic               sign_q, sign_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [15:0]        res_q, res_d;
    logic [15:0]        rnd_result;

    fix2flt_round u_round (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .mag_i    (mag_q),
        .result_o (rnd_result)
    );

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE:
                if (start_q && !bus.start) state_d = ST_LOAD_HI;
            ST_LOAD_HI: begin
                sign_d      = bus.dm_rd_data[7];
                mag_d[14:8] = bus.dm_rd_data[6:0];
                state_d     = ST_LOAD_LO;
            end
            ST_LOAD_LO: begin
                mag_d[7:0] = bus.dm_rd_data;
                exp_d      = EXP_INIT;
                state_d    = ST_NORM;
            end
            ST_NORM:
                if (mag_q == '0 || mag_q[MAG_W-1]) begin
                    state_d = ST_ROUND;
                end else begin
                    mag_d = {mag_q[MAG_W-2:0], 1'b0};
                    exp_d = exp_q - 1'b1;
                end
            ST_ROUND: begin
                res_d   = rnd_result;
                state_d = ST_STORE_HI;
            end
            ST_STORE_HI: state_d = ST_STORE_LO;
            ST_STORE_LO: state_d = ST_DONE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
        end
    end

    // Outputs decode from state and registered result only, so a reset
    // clears them in the same cycle it is asserted.
    always_comb begin
        bus.done       = (state_q == ST_DONE);
        bus.dm_wr_en   = (state_q == ST_STORE_HI) || (state_q == ST_STORE_LO);
        bus.dm_addr    = 8'd0;
        bus.dm_wr_data = 8'd0;
        case (state_q)
            ST_LOAD_HI:  bus.dm_addr = SRC_ADDR + 8'd1;
            ST_LOAD_LO:  bus.dm_addr = SRC_ADDR;
            ST_STORE_HI: begin
                bus.dm_addr    = DST_ADDR + 8'd1;
                bus.dm_wr_data = res_q[15:8];
            end
            ST_STORE_LO: begin
                bus.dm_addr    = DST_ADDR;
                bus.dm_wr_data = res_q[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fix2flt_core.sv
module tb_fix2flt_core;

    logic clk;
    logic reset;
    logic [7:0] mem [256];
    int n_checks;
    int n_fail;
    int n_done;
    int n_wr;

    fix2flt_if bus ();

    fix2flt_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.dm_rd_data = mem[bus.dm_addr];

    always @(posedge clk) begin
        if (bus.dm_wr_en) begin
            mem[bus.dm_addr] <= bus.dm_wr_data;
            n_wr <= n_wr + 1;
        end
        if (bus.done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic load(input logic [15:0] op);
        @(negedge clk);
        mem[0] = op[7:0];
        mem[1] = op[15:8];
        mem[2] = 8'hAD;
        mem[3] = 8'hDE;
    endtask

    task automatic convert(input string tag, input logic [15:0] op,
                           input logic [15:0] exp_res, input int exp_lat);
        int lat;
        int d0;
        int w0;
        load(op);
        d0 = n_done;
        w0 = n_wr;
        pulse_start();
        wait_done(lat);
        @(posedge clk);
        #1;
        chk({tag, "_res"}, {mem[3], mem[2]}, exp_res);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_done"}, n_done - d0, 1);
        chk({tag, "_wr"}, n_wr - w0, 2);
    endtask

    initial begin
        int lat;
        int d0;
        int w0;
        n_checks = 0;
        n_fail   = 0;
        n_done   = 0;
        n_wr     = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", bus.done, 0);
        chk("rst_wr_en", bus.dm_wr_en, 0);
        chk("rst_addr", bus.dm_addr, 0);
        chk("rst_wr_data", bus.dm_wr_data, 0);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);

        convert("one",      16'h0100, 16'h3C00, 12);
        convert("neg1p5",   16'h8180, 16'hBE00, 12);
        convert("exact",    16'h0123, 16'h3C8C, 12);
        convert("zero",     16'h0000, 16'h0000, 6);
        convert("negzero",  16'h8000, 16'h8000, 6);
        convert("lsb",      16'h0001, 16'h1C00, 20);
        convert("carry",    16'h7FFF, 16'h5800, 6);
        convert("tie_up",   16'h4018, 16'h5402, 6);
        convert("tie_even", 16'h4008, 16'h5400, 6);

        // Second start pulse lands in NORM and must be dropped.
        load(16'h0001);
        d0 = n_done;
        w0 = n_wr;
        pulse_start();
        repeat (5) @(posedge clk);
        pulse_start();
        wait_done(lat);
        chk("ign_lat", lat, 14);
        repeat (30) @(posedge clk);
        #1;
        chk("ign_res", {mem[3], mem[2]}, 16'h1C00);
        chk("ign_done", n_done - d0, 1);
        chk("ign_wr", n_wr - w0, 2);
        convert("after_ign", 16'h0100, 16'h3C00, 12);

        // Reset while normalizing.
        load(16'h0001);
        w0 = n_wr;
        pulse_start();
        repeat (5) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_wr_en", bus.dm_wr_en, 0);
        chk("mid_rst_addr", bus.dm_addr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("mid_rst_dst", {mem[3], mem[2]}, 16'hDEAD);
        chk("mid_rst_wr", n_wr - w0, 0);
        convert("after_rst", 16'h4018, 16'h5402, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
